// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Purpose:
//   Shares one (W+1)-bit ALU between two requesters. In IDLE, a round-robin
//   arbiter picks one pending requester and latches its opcode and operands.
//   EXEC computes the result from the latched copy in exactly one cycle and
//   registers it. RESP then holds the result until the granted requester
//   accepts it.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid[1:0]  bit i: requester i has an operation pending
//   req_ready[1:0]  bit i: requester i's operation is accepted this cycle
//                   (combinational, IDLE only, at most one bit set)
//   op0/A0/B0       requester 0 opcode and operands
//   op1/A1/B1       requester 1 opcode and operands
//   resp_valid[1:0] bit i: out/zero/carry hold requester i's result
//   resp_ready[1:0] bit i: requester i accepts the result
//   out, zero       shared result and its zero flag
//   carry           ADD carry-out / SUB borrow-not (A >= B unsigned), else 0
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int W = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [2:0]   op0,
    input  logic [W:0]   A0,
    input  logic [W:0]   B0,
    input  logic [2:0]   op1,
    input  logic [W:0]   A1,
    input  logic [W:0]   B1,
    output logic [1:0]   resp_valid,
    input  logic [1:0]   resp_ready,
    output logic [W:0]   out,
    output logic         zero,
    output logic         carry
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_reg;
    logic         last_grant_reg;
    logic         grant_reg;
    logic [2:0]   op_reg;
    logic [W:0]   a_reg;
    logic [W:0]   b_reg;

    logic         grant_next;
    logic         accept;

    // When both ports request, the port that did not win last time wins now.
    // With only one request pending, that port wins.
    always_comb begin
        grant_next = (req_valid == 2'b11) ? ~last_grant_reg : req_valid[1];
        // Gated by rst so that no handshake is shown while reset is held.
        accept     = (state_reg == IDLE) && (|req_valid) && !rst;
        req_ready  = accept ? (grant_next ? 2'b10 : 2'b01) : 2'b00;
    end

    // Bitwise gate banks, one gate of each kind per bit.
    logic [W:0] and_bits, or_bits, not_bits, xor_bits;

    generate
        for (genvar gi = 0; gi <= W; gi++) begin : g_gate_bank
            assign and_bits[gi] = a_reg[gi] & b_reg[gi];
            assign or_bits[gi]  = a_reg[gi] | b_reg[gi];
            assign not_bits[gi] = ~a_reg[gi];
            assign xor_bits[gi] = a_reg[gi] ^ b_reg[gi];
        end
    endgenerate

    // One adder does both ADD and SUB. SUB is A + ~B + 1, so its top bit is
    // the borrow-not flag (1 when A >= B unsigned).
    logic         is_sub;
    logic [W+1:0] sum_ext;
    logic [W:0]   alu_out;
    logic         alu_carry;

    always_comb begin
        is_sub    = (op_reg == 3'b101);
        sum_ext   = {1'b0, a_reg} + {1'b0, (is_sub ? ~b_reg : b_reg)}
                    + {{(W+1){1'b0}}, is_sub};
        alu_carry = 1'b0;
        case (op_reg)
            3'b000:  alu_out = and_bits;
            3'b001:  alu_out = or_bits;
            3'b010:  alu_out = not_bits;
            3'b011:  alu_out = xor_bits;
            3'b100: begin
                alu_out   = sum_ext[W:0];
                alu_carry = sum_ext[W+1];
            end
            3'b101: begin
                alu_out   = sum_ext[W:0];
                alu_carry = sum_ext[W+1];
            end
            3'b110:  alu_out = {{W{1'b0}}, ($signed(a_reg) < $signed(b_reg))};
            default: alu_out = b_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            grant_reg      <= 1'b0;
            op_reg         <= 3'b000;
            a_reg          <= '0;
            b_reg          <= '0;
            resp_valid     <= 2'b00;
            out            <= '0;
            zero           <= 1'b0;
            carry          <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg         <= grant_next ? op1 : op0;
                        a_reg          <= grant_next ? A1 : A0;
                        b_reg          <= grant_next ? B1 : B0;
                        grant_reg      <= grant_next;
                        last_grant_reg <= grant_next;
                        state_reg      <= EXEC;
                    end
                end
                EXEC: begin
                    out        <= alu_out;
                    zero       <= (alu_out == '0);
                    carry      <= alu_carry;
                    resp_valid <= grant_reg ? 2'b10 : 2'b01;
                    state_reg  <= RESP;
                end
                RESP: begin
                    // Only the granted port can complete the handshake.
                    // out/zero/carry keep their value afterwards.
                    if (resp_ready[grant_reg]) begin
                        resp_valid <= 2'b00;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int W = 31;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   op0, op1;
    logic [W:0]   A0, B0, A1, B1;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [W:0]   out;
    logic         zero;
    logic         carry;

    alu_share_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op0        (op0),
        .A0         (A0),
        .B0         (B0),
        .op1        (op1),
        .A1         (A1),
        .B1         (B1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out        (out),
        .zero       (zero),
        .carry      (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1);
    end

    typedef struct {
        logic        port;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_out;
        logic        exp_zero;
        logic        exp_carry;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs[NVEC];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive_port(input logic p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!p) begin
            op0 = op; A0 = a; B0 = b;
        end else begin
            op1 = op; A1 = a; B1 = b;
        end
    endtask

    // Waits (bounded) for a response, then compares it with the oldest entry in the scoreboard.
    task automatic expect_resp(input int exp_latency);
        int n;
        n = 0;
        while (resp_valid == 2'b00 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("resp_latency", n, exp_latency);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got response %b, expected none", resp_valid);
        end else begin
            vec_t e;
            e = sb.pop_front();
            check("resp_valid", resp_valid, e.port ? 2'b10 : 2'b01);
            check("out", out, e.exp_out);
            check("zero", zero, e.exp_zero);
            check("carry", carry, e.exp_carry);
            $display("resp port=%0d op=%b a=%h b=%h out=%h zero=%b carry=%b",
                     e.port, e.op, e.a, e.b, out, zero, carry);
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        resp_ready = 2'b11;
        drive_port(v.port, v.op, v.a, v.b);
        req_valid = v.port ? 2'b10 : 2'b01;
        #1;
        check("req_ready_idle", req_ready, v.port ? 2'b10 : 2'b01);
        sb.push_back(v);
        @(negedge clk);
        // EXEC: no grant although the request is still up; scramble the operands
        // so that a design that reads them live instead of the latched copy goes wrong.
        check("req_ready_exec", req_ready, 2'b00);
        drive_port(v.port, ~v.op, ~v.a, ~v.b);
        req_valid = 2'b00;
        @(negedge clk);
        expect_resp(0);
    endtask

    initial begin
        vec_t t;
        int n;

        vecs[0]  = '{1'b0, 3'b100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
        vecs[1]  = '{1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 3'b010, 32'h0000FFFF, 32'h12345678, 32'hFFFF0000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 3'b101, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'b101, 32'h00000005, 32'h00000003, 32'h00000002, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 3'b101, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 3'b110, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 3'b110, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'b001, 32'h0F0F0000, 32'h0000F0F0, 32'h0F0FF0F0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 3'b011, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'b111, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 3'b100, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b1};

        // Reset held for two cycles with a request pending: no handshake, outputs cleared.
        rst = 1'b1;
        req_valid = 2'b01;
        resp_ready = 2'b00;
        op0 = 3'b000; A0 = '0; B0 = '0;
        op1 = 3'b000; A1 = '0; B1 = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_resp_valid", resp_valid, 2'b00);
        check("rst_out", out, 32'h0);
        check("rst_zero", zero, 1'b0);
        check("rst_carry", carry, 1'b0);
        $display("reset state: req_ready=%b resp_valid=%b out=%h zero=%b carry=%b",
                 req_ready, resp_valid, out, zero, carry);
        rst = 1'b0;
        req_valid = 2'b00;

        // Table of single-requester operations.
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during EXEC: no response, outputs cleared, arbitration pointer reset.
        @(negedge clk);
        drive_port(1'b0, 3'b100, 32'h5, 32'h6);
        req_valid = 2'b01;
        #1;
        check("rm_grant", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        check("rm_resp_valid", resp_valid, 2'b00);
        check("rm_out", out, 32'h0);
        check("rm_carry", carry, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rm_no_resp", resp_valid, 2'b00);
        $display("reset mid-op: resp_valid=%b out=%h", resp_valid, out);

        // Contention with both ports requesting all the time: grants 0,1,0,1.
        @(negedge clk);
        resp_ready = 2'b11;
        drive_port(1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00);
        drive_port(1'b1, 3'b010, 32'h0000FFFF, 32'h00000000);
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 8) begin
                @(negedge clk);
                n++;
            end
            check("cont_grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            $display("contention grant %0d: req_ready=%b", k, req_ready);
            if (k % 2 == 0) t = '{1'b0, 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
            else            t = '{1'b1, 3'b010, 32'h0000FFFF, 32'h00000000, 32'hFFFF0000, 1'b0, 1'b0};
            sb.push_back(t);
            @(negedge clk);
            expect_resp(1);
        end
        req_valid = 2'b00;

        // Back-pressure: the result is held while port 0 does not accept; port 1 waits.
        @(negedge clk);
        resp_ready = 2'b00;
        drive_port(1'b0, 3'b100, 32'h00000010, 32'h00000020);
        req_valid = 2'b01;
        #1;
        check("bp_grant0", req_ready, 2'b01);
        t = '{1'b0, 3'b100, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0};
        sb.push_back(t);
        @(negedge clk);
        drive_port(1'b1, 3'b111, 32'h00000000, 32'hCAFEF00D);
        req_valid = 2'b10;
        @(negedge clk);
        expect_resp(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid, 2'b01);
            check("bp_out", out, 32'h00000030);
            check("bp_req_ready", req_ready, 2'b00);
            $display("back-pressure cycle %0d: resp_valid=%b out=%h req_ready=%b",
                     i, resp_valid, out, req_ready);
            // The non-granted accept bit must be ignored.
            resp_ready = (i >= 2) ? 2'b10 : 2'b00;
        end
        resp_ready = 2'b01;
        @(negedge clk);
        check("bp_next_grant", req_ready, 2'b10);
        check("bp_resp_dropped", resp_valid, 2'b00);
        check("bp_out_kept", out, 32'h00000030);
        t = '{1'b1, 3'b111, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};
        sb.push_back(t);
        resp_ready = 2'b11;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        expect_resp(0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
